// File: rtl/stage_b_fetch_data_pkg.sv
// Shared opcode constants and helpers for the fetch-data and write-back stages.
// Opcodes are one-hot; each OP_* value is the bit index of that opcode.
package stage_b_fetch_data_pkg;

  localparam int OP_INC       = 0;
  localparam int OP_DEC       = 1;
  localparam int OP_LEFT      = 2;
  localparam int OP_RIGHT     = 3;
  localparam int OP_IN        = 4;
  localparam int OP_OUT       = 5;
  localparam int OP_LOOPBEGIN = 6;
  localparam int OP_LOOPEND   = 7;
  localparam int OPCODE_MSB   = 7;

  // The write-back stage stores a new cell value for these operations.
  function automatic logic should_write_d(input logic [OPCODE_MSB:0] op);
    return op[OP_INC] | op[OP_DEC] | op[OP_IN];
  endfunction

  // These operations consume the current cell, so the cell must be fetched.
  function automatic logic needs_read(input logic [OPCODE_MSB:0] op);
    return op[OP_INC] | op[OP_DEC] | op[OP_OUT] | op[OP_LOOPBEGIN] | op[OP_LOOPEND];
  endfunction

endpackage

// File: rtl/stage_b_fetch_data_dram_snoop_cmp.sv
// Compares a pending DRAM address against the write-back write port and
// substitutes the data being written when they match.
module dram_snoop_cmp #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
) (
  input  logic               wb_ce_i,
  input  logic [A_WIDTH-1:0] wb_a_i,
  input  logic [D_WIDTH-1:0] wb_q_i,
  input  logic [A_WIDTH-1:0] addr_i,
  input  logic               need_i,
  input  logic [D_WIDTH-1:0] data_i,
  output logic               hit_o,
  output logic [D_WIDTH-1:0] data_o
);

  assign hit_o  = wb_ce_i && need_i && (wb_a_i == addr_i);
  assign data_o = hit_o ? wb_q_i : data_i;

endmodule

// File: rtl/stage_b_fetch_data.sv
// DRAM read stage between decode and ALU: fetches the cell at dp for each operation
// that consumes it. Optional macro RAW_FORWARD_EN forwards same-cycle writes instead of stalling.
module stage_b_fetch_data
  import stage_b_fetch_data_pkg::*;
#(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [A_WIDTH-1:0]    dp,
  output logic                  dce,
  output logic [A_WIDTH-1:0]    da,
  input  logic [D_WIDTH-1:0]    dd,
  input  logic                  wb_ce,
  input  logic [A_WIDTH-1:0]    wb_a,
  input  logic [D_WIDTH-1:0]    wb_q,
  input  logic [OPCODE_MSB:0]   operation_in,
  input  logic                  drdy_in,
  output logic                  ack,
  output logic [OPCODE_MSB:0]   operation,
  output logic [D_WIDTH-1:0]    a,
  output logic                  drdy,
  input  logic                  ack_in,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a transfer happens on an edge where valid (drdy_in / drdy) and the
  // matching accept (ack / ack_in) are both high; valid side holds its payload until then.

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_FETCH = 2'd1,
    SLOT_HELD  = 2'd2
  } slot_state_e;

  slot_state_e          state_q, state_d;
  logic [OPCODE_MSB:0]  s_op_q, s_op_d;
  logic [A_WIDTH-1:0]   s_addr_q, s_addr_d;
  logic                 s_need_q, s_need_d;
  logic [D_WIDTH-1:0]   s_data_q, s_data_d;
  logic [OPCODE_MSB:0]  op_q, op_d;
  logic [D_WIDTH-1:0]   a_q, a_d;
  logic                 drdy_q, drdy_d;

  logic                 in_need;
  logic                 collision;
  logic                 stall;
  logic                 slot_busy;
  logic                 out_free;
  logic                 accept;
  logic [D_WIDTH-1:0]   fetch_raw;
  logic [D_WIDTH-1:0]   slot_base;
  logic [D_WIDTH-1:0]   slot_cur;
  logic                 slot_hit;

  assign in_need   = needs_read(operation_in);
  // The RAM returns pre-write data when a read and a write hit the same cell together.
  assign collision = drdy_in && in_need && wb_ce && (wb_a == dp);

`ifdef RAW_FORWARD_EN
  logic                 raw_q, raw_d;
  logic [D_WIDTH-1:0]   raw_data_q, raw_data_d;

  assign stall      = 1'b0;
  assign raw_d      = accept && collision;
  assign raw_data_d = wb_q;
  assign fetch_raw  = raw_q ? raw_data_q : dd;

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q      <= 1'b0;
      raw_data_q <= '0;
    end else begin
      raw_q      <= raw_d;
      raw_data_q <= raw_data_d;
    end
  end
`else
  assign stall     = collision;
  assign fetch_raw = dd;
`endif

  assign slot_busy = (state_q != SLOT_EMPTY);
  assign out_free  = !drdy_q || ack_in;
  assign ack       = !reset && !stall && (!slot_busy || out_free);
  assign accept    = drdy_in && ack;
  assign dce       = accept && in_need;
  assign da        = dp;

  // dd only matters in the cycle right after a real read was issued.
  assign slot_base = (state_q == SLOT_FETCH) ? (s_need_q ? fetch_raw : '0) : s_data_q;

  dram_snoop_cmp #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_slot_snoop (
    .wb_ce_i (wb_ce),
    .wb_a_i  (wb_a),
    .wb_q_i  (wb_q),
    .addr_i  (s_addr_q),
    .need_i  (s_need_q && slot_busy),
    .data_i  (slot_base),
    .hit_o   (slot_hit),
    .data_o  (slot_cur)
  );

  always_comb begin
    state_d  = state_q;
    s_op_d   = s_op_q;
    s_addr_d = s_addr_q;
    s_need_d = s_need_q;
    s_data_d = slot_cur;
    op_d     = op_q;
    a_d      = a_q;
    drdy_d   = drdy_q;

    if (out_free) begin
      if (slot_busy) begin
        op_d   = s_op_q;
        a_d    = slot_cur;
        drdy_d = 1'b1;
      end else begin
        op_d   = '0;
        a_d    = '0;
        drdy_d = 1'b0;
      end
    end

    case (state_q)
      SLOT_EMPTY: begin
        if (accept) state_d = SLOT_FETCH;
      end
      SLOT_FETCH, SLOT_HELD: begin
        if (out_free) state_d = accept ? SLOT_FETCH : SLOT_EMPTY;
        else          state_d = SLOT_HELD;
      end
      default: state_d = SLOT_EMPTY;
    endcase

    if (accept) begin
      s_op_d   = operation_in;
      s_addr_d = dp;
      s_need_d = in_need;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SLOT_EMPTY;
      s_op_q   <= '0;
      s_addr_q <= '0;
      s_need_q <= 1'b0;
      s_data_q <= '0;
      op_q     <= '0;
      a_q      <= '0;
      drdy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_op_q   <= s_op_d;
      s_addr_q <= s_addr_d;
      s_need_q <= s_need_d;
      s_data_q <= s_data_d;
      op_q     <= op_d;
      a_q      <= a_d;
      drdy_q   <= drdy_d;
    end
  end

  assign operation   = op_q;
  assign a           = a_q;
  assign drdy        = drdy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stage_b_fetch_data.sv
// Directed bench for stage_b_fetch_data with a read-first DRAM model; the collision
// case expects zero bubbles when RAW_FORWARD_EN is defined and one otherwise.
module tb_stage_b_fetch_data;
  import stage_b_fetch_data_pkg::*;

  localparam logic [7:0] OPV_INC = 8'(1 << OP_INC);
  localparam logic [7:0] OPV_DEC = 8'(1 << OP_DEC);
  localparam logic [7:0] OPV_IN  = 8'(1 << OP_IN);
  localparam logic [7:0] OPV_OUT = 8'(1 << OP_OUT);
`ifdef RAW_FORWARD_EN
  localparam int EXP_STALLS = 0;
`else
  localparam int EXP_STALLS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] dp;
  logic        dce;
  logic [11:0] da;
  logic [7:0]  dd = 8'h00;
  logic        wb_ce;
  logic [11:0] wb_a;
  logic [7:0]  wb_q;
  logic [7:0]  operation_in;
  logic        drdy_in;
  logic        ack;
  logic [7:0]  operation;
  logic [7:0]  a;
  logic        drdy;
  logic        ack_in;
  logic [1:0]  dbg_state;

  logic [7:0]  mem [0:4095];
  int          total = 0;
  int          bad = 0;

  stage_b_fetch_data #(.A_WIDTH(12), .D_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .dp(dp), .dce(dce), .da(da), .dd(dd),
    .wb_ce(wb_ce), .wb_a(wb_a), .wb_q(wb_q),
    .operation_in(operation_in), .drdy_in(drdy_in), .ack(ack),
    .operation(operation), .a(a), .drdy(drdy), .ack_in(ack_in),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Read-first RAM: a read and write of the same cell on one edge returns old data.
  always @(posedge clk) begin
    if (dce) dd <= mem[da];
    if (wb_ce) mem[wb_a] = wb_q;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    mem[5] = 8'h3C;
    reset = 1'b1; drdy_in = 1'b1; operation_in = OPV_INC; dp = 12'd5;
    ack_in = 1'b1; wb_ce = 1'b0; wb_a = '0; wb_q = '0;
    tick(); tick();
    total++; if (dce !== 1'b0) begin bad++; $display("FAIL reset_dce: got %b want 0", dce); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
    total++; if (drdy !== 1'b0) begin bad++; $display("FAIL reset_drdy: got %b want 0", drdy); end
    total++; if (operation !== 8'h00) begin bad++; $display("FAIL reset_op: got %h want 00", operation); end
    total++; if (a !== 8'h00) begin bad++; $display("FAIL reset_a: got %h want 00", a); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    // Accept one op, then reset while it is in flight.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL midreset_ack: got %b want 0", ack); end
    total++; if (dce !== 1'b0) begin bad++; $display("FAIL midreset_dce: got %b want 0", dce); end
    tick();
    total++; if (drdy !== 1'b0 || operation !== 8'h00) begin
      bad++; $display("FAIL midreset_out: drdy=%b op=%h want 0/00", drdy, operation);
    end
    reset = 1'b0; drdy_in = 1'b0; operation_in = '0;
    tick();
    total++; if (drdy !== 1'b0) begin bad++; $display("FAIL midreset_slot: got drdy=%b want 0", drdy); end
  endtask

  task automatic test_stream;
    mem[5] = 8'h3C;
    dp = 12'd5; operation_in = OPV_INC; drdy_in = 1'b1; ack_in = 1'b1; wb_ce = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (ack !== 1'b1 || dce !== 1'b1 || da !== 12'd5) begin
        bad++; $display("FAIL stream_issue[%0d]: ack=%b dce=%b da=%0d want 1/1/5", i, ack, dce, da);
      end
      tick();
      if (i == 0) begin
        total++; if (drdy !== 1'b0) begin bad++; $display("FAIL stream_latency: drdy=%b want 0", drdy); end
      end else begin
        total++; if (drdy !== 1'b1 || a !== 8'h3C || operation !== OPV_INC) begin
          bad++; $display("FAIL stream_out[%0d]: drdy=%b a=%h op=%h want 1/3c/%h", i, drdy, a, operation, OPV_INC);
        end
      end
    end
    drdy_in = 1'b0; operation_in = '0;
    tick();
    total++; if (drdy !== 1'b1 || a !== 8'h3C) begin bad++; $display("FAIL stream_last: drdy=%b a=%h want 1/3c", drdy, a); end
    tick();
    total++; if (drdy !== 1'b0 || operation !== 8'h00) begin
      bad++; $display("FAIL stream_bubble: drdy=%b op=%h want 0/00", drdy, operation);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    logic [7:0] prev_a, prev_op;
    logic       prev_stall;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_a = '0; prev_op = '0;
    for (int k = 0; k < 8; k++) mem[16 + k] = 8'(8'h40 + k);
    operation_in = OPV_INC; wb_ce = 1'b0;
    while (recv < 8 && cyc < 40) begin
      drdy_in = (sent < 8);
      dp = 12'(16 + sent);
      ack_in = !(cyc >= 3 && cyc < 7);
      #1;
      if (prev_stall) begin
        total++; if (drdy !== 1'b1 || a !== prev_a || operation !== prev_op) begin
          bad++; $display("FAIL bp_stable[%0d]: drdy=%b a=%h op=%h want 1/%h/%h", cyc, drdy, a, operation, prev_a, prev_op);
        end
      end
      if (cyc >= 3 && cyc < 7) begin
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL bp_ack[%0d]: got %b want 0", cyc, ack); end
      end
      if (cyc >= 4 && cyc < 7) begin
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL bp_held[%0d]: got %0d want 2", cyc, dbg_state); end
      end
      if (drdy_in && ack) begin
        exp_q.push_back(8'(8'h40 + sent));
        sent++;
      end
      if (drdy && ack_in) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        total++; if (a !== exp_v || operation !== OPV_INC) begin
          bad++; $display("FAIL bp_data[%0d]: a=%h op=%h want %h/%h", recv, a, operation, exp_v, OPV_INC);
        end
        recv++;
      end
      prev_stall = drdy && !ack_in;
      prev_a = a; prev_op = operation;
      tick();
      cyc++;
    end
    total++; if (recv != 8 || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_count: recv=%0d left=%0d want 8/0", recv, exp_q.size());
    end
    drdy_in = 1'b0; operation_in = '0; ack_in = 1'b1;
    tick(); tick();
  endtask

  task automatic test_snoop;
    mem[6] = 8'h66; mem[7] = 8'h22;
    ack_in = 1'b0; wb_ce = 1'b0;
    dp = 12'd6; operation_in = OPV_INC; drdy_in = 1'b1;
    tick();
    dp = 12'd7; operation_in = OPV_OUT;
    #1;
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL snoop_ack: got %b want 1", ack); end
    tick();
    drdy_in = 1'b0; operation_in = '0;
    tick();
    total++; if (dbg_state !== 2'd2 || drdy !== 1'b1 || a !== 8'h66) begin
      bad++; $display("FAIL snoop_hold: state=%0d drdy=%b a=%h want 2/1/66", dbg_state, drdy, a);
    end
    wb_ce = 1'b1; wb_a = 12'd7; wb_q = 8'h11;
    tick();
    wb_ce = 1'b0; ack_in = 1'b1;
    #1;
    total++; if (a !== 8'h66 || operation !== OPV_INC) begin
      bad++; $display("FAIL snoop_first: a=%h op=%h want 66/%h", a, operation, OPV_INC);
    end
    tick();
    total++; if (drdy !== 1'b1 || a !== 8'h11 || operation !== OPV_OUT) begin
      bad++; $display("FAIL snoop_data: drdy=%b a=%h op=%h want 1/11/%h", drdy, a, operation, OPV_OUT);
    end
    tick();
  endtask

  task automatic test_collision;
    int stalls, cyc;
    stalls = 0; cyc = 0;
    mem[9] = 8'h55;
    ack_in = 1'b1; dp = 12'd9; operation_in = OPV_DEC; drdy_in = 1'b1;
    wb_ce = 1'b1; wb_a = 12'd9; wb_q = 8'h80;
    #1;
    while (!ack && cyc < 4) begin
      total++; if (dce !== 1'b0) begin bad++; $display("FAIL coll_dce_stall: got %b want 0", dce); end
      stalls++;
      tick();
      wb_ce = 1'b0;
      cyc++;
      #1;
    end
    total++; if (!ack || !dce) begin bad++; $display("FAIL coll_accept: ack=%b dce=%b want 1/1", ack, dce); end
    tick();
    wb_ce = 1'b0; drdy_in = 1'b0; operation_in = '0;
    total++; if (stalls != EXP_STALLS) begin bad++; $display("FAIL coll_bubbles: got %0d want %0d", stalls, EXP_STALLS); end
    total++; if (drdy !== 1'b0) begin bad++; $display("FAIL coll_latency: drdy=%b want 0", drdy); end
    tick();
    total++; if (drdy !== 1'b1 || a !== 8'h80 || operation !== OPV_DEC) begin
      bad++; $display("FAIL coll_data: drdy=%b a=%h op=%h want 1/80/%h", drdy, a, operation, OPV_DEC);
    end
    tick();
  endtask

  task automatic test_non_read;
    mem[11] = 8'h77;
    ack_in = 1'b1; wb_ce = 1'b0; dp = 12'd11; operation_in = OPV_IN; drdy_in = 1'b1;
    #1;
    total++; if (ack !== 1'b1 || dce !== 1'b0) begin bad++; $display("FAIL nonread_issue: ack=%b dce=%b want 1/0", ack, dce); end
    tick();
    drdy_in = 1'b0; operation_in = '0;
    total++; if (drdy !== 1'b0) begin bad++; $display("FAIL nonread_latency: drdy=%b want 0", drdy); end
    tick();
    total++; if (drdy !== 1'b1 || a !== 8'h00 || operation !== OPV_IN) begin
      bad++; $display("FAIL nonread_out: drdy=%b a=%h op=%h want 1/00/%h", drdy, a, operation, OPV_IN);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; dp = '0; wb_ce = 1'b0; wb_a = '0; wb_q = '0;
    operation_in = '0; drdy_in = 1'b0; ack_in = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_snoop();
    test_collision();
    test_non_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
